// File: rtl/apb_mst_pkg.sv
// apb_mst_pkg: shared state encoding, default widths and timeout counter sizing for the APB master.
package apb_mst_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    localparam int unsigned DEF_ADDR_WIDTH     = 32;
    localparam int unsigned DEF_DATA_WIDTH     = 32;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 255;

    function automatic int unsigned timeout_width(input int unsigned cycles);
        return $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/apb_mst_timeout.sv
// apb_mst_timeout: ACCESS wait-state counter that flags expiry on the last allowed cycle without pready.
module apb_mst_timeout
    import apb_mst_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic waiting,
    output logic expired
);

    localparam int unsigned W = timeout_width(TIMEOUT_CYCLES);

    logic [W-1:0] count;

    // Count holds the number of wait cycles already seen, so expiry fires on the cycle that would make it TIMEOUT_CYCLES.
    assign expired = waiting && (count == W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (rst || start)
            count <= '0;
        else if (waiting && !expired)
            count <= count + W'(1);
    end

endmodule

// File: rtl/apb_master_interface.sv
// apb_master_interface: valid/ready request port to APB SETUP/ACCESS initiator with one-cycle response pulse.
// Optional ACCESS timeout abort is enabled by defining APB_MST_TIMEOUT_EN.
module apb_master_interface
    import apb_mst_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                  apb_pclk_i,
    input  logic                  apb_preset_i,
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_write_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    output logic                  resp_valid_o,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    output logic [ADDR_WIDTH-1:0] apb_paddr_o,
    output logic                  apb_psel_o,
    output logic                  apb_penable_o,
    output logic                  apb_pwrite_o,
    output logic [DATA_WIDTH-1:0] apb_pwdata_o,
    input  logic                  apb_pready_i,
    input  logic [DATA_WIDTH-1:0] apb_prdata_i
);

    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES out of range");
    end

    state_t state, next;
    logic   done, abort;

    assign done        = (state == ACCESS) && apb_pready_i;
    assign req_ready_o = (state == IDLE);

`ifdef APB_MST_TIMEOUT_EN
    apb_mst_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk    (apb_pclk_i),
        .rst    (apb_preset_i),
        .start  (state == SETUP),
        .waiting((state == ACCESS) && !apb_pready_i),
        .expired(abort)
    );
`else
    assign abort = 1'b0;
`endif

    always_ff @(posedge apb_pclk_i) begin
        if (apb_preset_i)
            state <= IDLE;
        else
            state <= next;
    end

    always_comb begin
        next = state;
        unique case (state)
            IDLE:    next = req_valid_i ? SETUP : IDLE;
            SETUP:   next = ACCESS;
            ACCESS:  next = (done || abort) ? IDLE : ACCESS;
            default: next = IDLE;
        endcase
    end

    // APB controls are decoded from the next state so they change on the same edge as the FSM.
    always_ff @(posedge apb_pclk_i) begin
        if (apb_preset_i) begin
            apb_paddr_o   <= '0;
            apb_pwdata_o  <= '0;
            apb_pwrite_o  <= 1'b0;
            apb_psel_o    <= 1'b0;
            apb_penable_o <= 1'b0;
            resp_valid_o  <= 1'b0;
            resp_rdata_o  <= '0;
            resp_err_o    <= 1'b0;
        end else begin
            apb_psel_o    <= (next != IDLE);
            apb_penable_o <= (next == ACCESS);
            resp_valid_o  <= done || abort;
            resp_err_o    <= abort;
            if (state == IDLE && req_valid_i) begin
                apb_paddr_o  <= req_addr_i;
                apb_pwdata_o <= req_wdata_i;
                apb_pwrite_o <= req_write_i;
            end
            if (done || abort)
                resp_rdata_o <= (done && !apb_pwrite_o) ? apb_prdata_i : '0;
        end
    end

endmodule

// File: tb/tb_apb_master_interface.sv
// tb_apb_master_interface: directed bench with response scoreboard and wait-state APB target model.
// Timeout scenarios run only when APB_MST_TIMEOUT_EN is defined.
module tb_apb_master_interface;

    localparam int TO = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_write = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        resp_valid, resp_err;
    logic [31:0] resp_rdata;
    logic [31:0] paddr, pwdata, prdata;
    logic        psel, penable, pwrite, pready;

    int          cyc = 0;
    int          wait_n = 0;
    logic [31:0] rd_val = '0;
    logic [7:0]  acc = '0;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          due;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] aq[$];
    int          total = 0, bad = 0, last = -1;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Target inserts wait_n wait states, then asserts pready.
    always @(posedge clk) acc <= (psel && penable && !pready) ? acc + 8'd1 : 8'd0;
    assign pready = psel && penable && (int'(acc) >= wait_n);
    assign prdata = rd_val;

    apb_master_interface #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .apb_pclk_i   (clk),
        .apb_preset_i (rst),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_write_i  (req_write),
        .req_addr_i   (req_addr),
        .req_wdata_i  (req_wdata),
        .resp_valid_o (resp_valid),
        .resp_rdata_o (resp_rdata),
        .resp_err_o   (resp_err),
        .apb_paddr_o  (paddr),
        .apb_psel_o   (psel),
        .apb_penable_o(penable),
        .apb_pwrite_o (pwrite),
        .apb_pwdata_o (pwdata),
        .apb_pready_i (pready),
        .apb_prdata_i (prdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        exp_t e;
        @(negedge clk);
        if (resp_valid) begin
            if (sb.size() == 0) begin
                chk("unexpected_resp", {31'b0, resp_valid}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("resp_rdata", resp_rdata, e.rdata);
                chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
                chk("resp_cycle", cyc, e.due);
            end
        end
    endtask

    task automatic issue(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input int wt, input logic want_resp, input logic err);
        exp_t e;
        req_valid = 1'b1;
        req_write = w;
        req_addr  = a;
        req_wdata = d;
        wait_n    = wt;
        for (int i = 0; i < 20; i++) begin
            if (req_ready) begin
                e.rdata = (w || err) ? 32'd0 : rd_val;
                e.err   = err;
                e.due   = cyc + (err ? 2 + TO : 3 + wt);
                if (want_resp) sb.push_back(e);
                tick();
                req_valid = 1'b0;
                return;
            end
            tick();
        end
        chk("accept_bound", {31'b0, req_ready}, 32'd1);
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 300; i++) begin
            if (sb.size() == 0) return;
            tick();
        end
        chk("drain_bound", sb.size(), 32'd0);
    endtask

    initial begin
        tick();
        tick();
        chk("rst_ready", {31'b0, req_ready}, 32'd1);
        chk("rst_psel", {31'b0, psel}, 32'd0);
        chk("rst_penable", {31'b0, penable}, 32'd0);
        chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        chk("rst_resp_err", {31'b0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_paddr", paddr, 32'd0);
        chk("rst_pwdata", pwdata, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite}, 32'd0);
        rst = 1'b0;
        tick();

        // Zero-wait write.
        issue(1'b1, 32'h14, 32'h0000_0ABC, 0, 1'b1, 1'b0);
        chk("wr_setup_psel", {31'b0, psel}, 32'd1);
        chk("wr_setup_penable", {31'b0, penable}, 32'd0);
        chk("wr_setup_pwrite", {31'b0, pwrite}, 32'd1);
        chk("wr_setup_pwdata", pwdata, 32'h0000_0ABC);
        chk("wr_setup_paddr", paddr, 32'h14);
        chk("wr_setup_ready", {31'b0, req_ready}, 32'd0);
        tick();
        chk("wr_access_psel", {31'b0, psel}, 32'd1);
        chk("wr_access_penable", {31'b0, penable}, 32'd1);
        chk("wr_access_pwrite", {31'b0, pwrite}, 32'd1);
        chk("wr_access_pwdata", pwdata, 32'h0000_0ABC);
        tick();
        chk("wr_done_psel", {31'b0, psel}, 32'd0);
        chk("wr_done_ready", {31'b0, req_ready}, 32'd1);
        wait_done();

        // Read with three wait states.
        rd_val = 32'hDEAD_BEEF;
        issue(1'b0, 32'h20, 32'h0, 3, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("rd_paddr_stable", paddr, 32'h20);
            chk("rd_pwrite_stable", {31'b0, pwrite}, 32'd0);
            tick();
        end
        wait_done();

        // Back-to-back requests with a changing address every cycle.
        rd_val    = 32'h1234_5678;
        wait_n    = 0;
        req_write = 1'b0;
        req_valid = 1'b1;
        for (int i = 0; i < 12; i++) begin
            req_addr = 32'h100 + 32'(i * 4);
            if (req_ready) begin
                aq.push_back(req_addr);
                sb.push_back('{rdata: rd_val, err: 1'b0, due: cyc + 3});
                if (last >= 0) chk("accept_spacing", cyc - last, 32'd3);
                last = cyc;
            end else if (psel && !penable && aq.size() > 0) begin
                chk("burst_paddr", paddr, aq.pop_front());
            end
            tick();
        end
        req_valid = 1'b0;
        wait_done();

        // Reset in the second ACCESS cycle drops the transfer silently.
        issue(1'b0, 32'h40, 32'h0, 100, 1'b0, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        chk("mid_rst_psel", {31'b0, psel}, 32'd0);
        chk("mid_rst_penable", {31'b0, penable}, 32'd0);
        chk("mid_rst_ready", {31'b0, req_ready}, 32'd1);
        chk("mid_rst_resp_valid", {31'b0, resp_valid}, 32'd0);
        rst = 1'b0;
        tick();
        tick();
        rd_val = 32'hCAFE_F00D;
        issue(1'b0, 32'h44, 32'h0, 1, 1'b1, 1'b0);
        wait_done();

`ifdef APB_MST_TIMEOUT_EN
        // Target never responds: abort after TO ACCESS cycles.
        rd_val = 32'h5555_AAAA;
        issue(1'b0, 32'h60, 32'h0, 100, 1'b1, 1'b1);
        for (int i = 0; i < TO + 1; i++) tick();
        chk("to_resp_valid", {31'b0, resp_valid}, 32'd1);
        chk("to_resp_err", {31'b0, resp_err}, 32'd1);
        chk("to_psel", {31'b0, psel}, 32'd0);
        chk("to_penable", {31'b0, penable}, 32'd0);
        wait_done();

        // pready arrives on the limit cycle: normal completion wins.
        rd_val = 32'h0BAD_CAFE;
        issue(1'b0, 32'h64, 32'h0, TO - 1, 1'b1, 1'b0);
        wait_done();
`endif

        tick();
        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
